// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with one-outstanding imem port and IF/ID register
// Redirect wins over stall and response; a request in flight at redirect is drained via drop_q.
module fetch_stage #(
    parameter int               DATAW     = 32,
    parameter logic [DATAW-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DATAW-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    output logic [DATAW-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [DATAW-1:0] imem_resp_data,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [DATAW-1:0] redirect_pc,
    output logic [DATAW-1:0] instr_out,
    output logic [DATAW-1:0] pc_out,
    output logic             instr_valid
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [DATAW-1:0] pc_q, pc_d;
    logic             drop_q, drop_d;
    logic [DATAW-1:0] hold_q, hold_d;
    logic [DATAW-1:0] instr_q, instr_d;
    logic [DATAW-1:0] pc_out_q, pc_out_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            hold_q   <= NOP_INSTR;
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            hold_q   <= hold_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        hold_d   = hold_q;
        pc_out_d = pc_out_q;
        // Stall freezes the IF/ID register; otherwise it decays to a bubble.
        instr_d  = stall ? instr_q : NOP_INSTR;
        valid_d  = stall ? valid_q : 1'b0;

        if (redirect_valid) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            pc_d    = redirect_pc & ~DATAW'(3);
            unique case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (!stall) begin
                            instr_d  = imem_resp_data;
                            pc_out_d = pc_q;
                            valid_d  = 1'b1;
                            pc_d     = pc_q + DATAW'(4);
                            state_d  = S_REQ;
                        end else begin
                            hold_d  = imem_resp_data;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_d  = hold_q;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + DATAW'(4);
                        state_d  = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    assign imem_req_valid = rst_n && (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_out      = instr_q;
    assign pc_out         = pc_out_q;
    assign instr_valid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector table, hand sequences and random run for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, rdy, rv, st, rd, ival;
    logic [31:0] req_addr, rdata, rdpc, instr, pco;

    logic        d2_req_valid, d2_rdy, d2_rv, d2_ival;
    logic [31:0] d2_req_addr, d2_rdata, d2_instr, d2_pco;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(rdy),
        .imem_resp_valid(rv), .imem_resp_data(rdata),
        .stall(st), .redirect_valid(rd), .redirect_pc(rdpc),
        .instr_out(instr), .pc_out(pco), .instr_valid(ival)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(d2_req_valid), .imem_req_addr(d2_req_addr), .imem_req_ready(d2_rdy),
        .imem_resp_valid(d2_rv), .imem_resp_data(d2_rdata),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_out(d2_instr), .pc_out(d2_pco), .instr_valid(d2_ival)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        st = 0; rd = 0; rdpc = '0; rdy = 0; rv = 0; rdata = '0;
        d2_rdy = 0; d2_rv = 0; d2_rdata = '0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_req_valid", 32'(req_valid), 32'd0);
        end
        chk("rst_instr", instr, NOP);
        chk("rst_pc_out", pco, 32'h0);
        chk("rst_valid", 32'(ival), 32'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        st, rd;
        logic [31:0] rdpc;
        logic        rdy, rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr, e_instr, e_pc;
        logic        e_val;
    } vec_t;

    vec_t tbl [28];

    logic        p_req, p_val, acc, outst;
    logic [31:0] p_addr, p_instr, p_pc, exp_pc, mem_addr;
    int          delay, delivered;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h0,   NOP,           32'h0,   1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0,   32'h1111_1111, 32'h0,   1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h4,   NOP,           32'h0,   1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h4,   32'h2222_2222, 32'h4,   1'b1};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h8,   NOP,           32'h4,   1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h8,   NOP,           32'h4,   1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'h8,   NOP,           32'h4,   1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'h8,   NOP,           32'h4,   1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'h8,   32'h3333_3333, 32'h8,   1'b1};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'hC,   NOP,           32'h8,   1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'hC,   NOP,           32'h8,   1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,         1'b0, 32'hC,   NOP,           32'h8,   1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4444_4444, 1'b0, 32'h200, NOP,           32'h8,   1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h200, NOP,           32'h8,   1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'h200, 32'h5555_5555, 32'h200, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 32'h103, 1'b0, 1'b0, 32'h0,         1'b1, 32'h204, NOP,           32'h200, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h100, NOP,           32'h200, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h6666_6666, 1'b0, 32'h100, NOP,           32'h200, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0,         1'b1, 32'h300, NOP,           32'h200, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h7777_7777, 1'b0, 32'h400, NOP,           32'h200, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h400, NOP,           32'h200, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8888_8888, 1'b0, 32'h400, 32'h8888_8888, 32'h400, 1'b1};
        tbl[22] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h404, 32'h8888_8888, 32'h400, 1'b1};
        tbl[23] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h404, NOP,           32'h400, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h404, NOP,           32'h400, 1'b0};
        tbl[25] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h9999_9999, 1'b0, 32'h404, NOP,           32'h400, 1'b0};
        tbl[26] = '{1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0,         1'b0, 32'h404, NOP,           32'h400, 1'b0};
        tbl[27] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h500, NOP,           32'h400, 1'b0};

        do_reset();
        for (int i = 0; i < 28; i++) begin
            st = tbl[i].st; rd = tbl[i].rd; rdpc = tbl[i].rdpc;
            rdy = tbl[i].rdy; rv = tbl[i].rv; rdata = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d_req_valid", i), 32'(req_valid), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_req_addr", i), req_addr, tbl[i].e_addr);
            @(posedge clk); #1;
            chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
            chk($sformatf("v%0d_pc_out", i), pco, tbl[i].e_pc);
            chk($sformatf("v%0d_valid", i), 32'(ival), 32'(tbl[i].e_val));
        end

        // Random run: delivered stream must be the sequential program from the last redirect target.
        do_reset();
        exp_pc = 32'h0; outst = 1'b0; delay = 0; delivered = 0; mem_addr = '0;
        for (int n = 0; n < 3000; n++) begin
            #1;
            p_req = req_valid; p_addr = req_addr;
            p_instr = instr; p_pc = pco; p_val = ival;
            if (outst) chk("one_outstanding", 32'(p_req), 32'd0);
            acc = p_req && rdy;
            if (acc && !rd) chk("rand_req_addr", p_addr, exp_pc);
            @(posedge clk); #1;
            if (rd) begin
                chk("rand_redir_valid", 32'(ival), 32'd0);
                chk("rand_redir_instr", instr, NOP);
                exp_pc = rdpc & ~32'd3;
            end else if (st) begin
                chk("rand_stall_instr", instr, p_instr);
                chk("rand_stall_pc", pco, p_pc);
                chk("rand_stall_valid", 32'(ival), 32'(p_val));
            end else if (ival) begin
                chk("rand_deliver_pc", pco, exp_pc);
                chk("rand_deliver_instr", instr, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                chk("rand_bubble_instr", instr, NOP);
                chk("rand_bubble_pc", pco, p_pc);
            end
            if (rv) outst = 1'b0;
            if (acc) begin
                outst = 1'b1;
                mem_addr = p_addr;
                delay = int'($urandom_range(0, 2));
            end
            st   = ($urandom_range(0, 3) == 0);
            rd   = ($urandom_range(0, 19) == 0);
            rdpc = $urandom();
            rdy  = ($urandom_range(0, 2) != 0);
            if (outst && delay == 0) begin
                rv = 1'b1;
                rdata = memf(mem_addr);
            end else begin
                rv = 1'b0;
                rdata = $urandom();
                if (outst) delay--;
            end
        end
        chk("rand_liveness", 32'(delivered > 100), 32'd1);

        // PC wrap from the top of the address space.
        do_reset();
        #1;
        chk("wrap_req_valid0", 32'(d2_req_valid), 32'd1);
        chk("wrap_addr0", d2_req_addr, 32'hFFFF_FFFC);
        d2_rdy = 1'b1;
        @(posedge clk); #1;
        d2_rdy = 1'b0; d2_rv = 1'b1; d2_rdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        d2_rv = 1'b0;
        chk("wrap_instr", d2_instr, 32'hCAFE_0001);
        chk("wrap_pc_out", d2_pco, 32'hFFFF_FFFC);
        chk("wrap_valid", 32'(d2_ival), 32'd1);
        #1;
        chk("wrap_req_valid1", 32'(d2_req_valid), 32'd1);
        chk("wrap_addr1", d2_req_addr, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
